normalize_param: RTL
====================

NORMALIZE_PARAM -- requirements
Module: normalize_param

Interface
REQ-001 SHALL have parameter EXP_W, default 5, meaning the exponent field width; legal range 3..11.
REQ-002 SHALL have parameter MAN_W, default 10, meaning the stored mantissa width; legal range 2..52, with MAN_W < 3*2^(EXP_W-1).
REQ-003 SHALL derive BIAS = 2^(EXP_W-1)-1 and XW = EXP_W+2 internally; they are not overridable.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 enable  in  1  block enable; low synchronously flushes the buffer.
REQ-007 s_valid  in  1  upstream operand valid.
REQ-008 s_ready  out  1  block can accept an operand this cycle.
REQ-009 sign_in / exp_in / mant_in  in  1 / EXP_W / MAN_W  raw IEEE-style fields.
REQ-010 n_valid  out  1  head result valid.
REQ-011 n_ready  in  1  downstream accepts head result.
REQ-012 sign_out / exp_out / mant_out  out  1 / XW signed / MAN_W+1  normalized result.
REQ-013 is_num / is_zero / is_nan / is_pinf / is_ninf  out  1 each  class flags of the head result.

Function
REQ-014 SHALL classify internally: exp all-ones with mant≠0 is NaN; exp all-ones with mant=0 is +inf (sign 0) or -inf (sign 1); exp=0 with mant=0 is zero; exp=0 with mant≠0 is subnormal; otherwise normal.
REQ-015 Normal: mant_out = {1, mant_in}; exp_out = exp_in - BIAS, two's-complement in XW bits.
REQ-016 Subnormal: with clz = number of leading zeros of mant_in (0..MAN_W-1), mant_out = {0, mant_in} << (clz+1), truncated to MAN_W+1 bits (MSB = 1); exp_out = -BIAS - clz.
REQ-017 Zero: mant_out = 0; exp_out = -BIAS; is_zero = 1; is_num = 1.
REQ-018 NaN/inf: mant_out = {0, mant_in}; exp_out = exp_in zero-extended; is_num = 0; exactly one of is_nan/is_pinf/is_ninf = 1.
REQ-019 is_num SHALL equal NOT(is_nan OR is_pinf OR is_ninf); sign_out SHALL always equal the captured sign_in, including zero and NaN.
REQ-020 Results SHALL be held in a 2-entry in-order buffer (skid), written with the classified/normalized value in the accept cycle.
REQ-021 An accept occurs when s_valid && s_ready && enable; a pop occurs when n_valid && n_ready.
REQ-022 s_ready SHALL be a registered signal, high iff occupancy < 2 and enable = 1 was sampled in the previous cycle and not in reset.
REQ-023 Latency: an accept into an empty buffer SHALL give n_valid = 1 on the next cycle, with that result on the outputs.
REQ-024 Accept and pop in the same cycle SHALL leave the occupancy unchanged and preserve order.
REQ-025 When full (occupancy 2), s_ready = 0; an operand offered then is not accepted and SHALL be held by upstream.
REQ-026 While n_valid = 1 and n_ready = 0, all result outputs SHALL stay stable.
REQ-027 When n_valid = 0, the result outputs and flags SHALL read all-zero.
REQ-028 enable = 0 at a rising edge SHALL empty the buffer (n_valid = 0 and outputs zero next cycle), drop any pending results, and accept nothing that cycle.

Reset
REQ-029 rst = 1 at a rising edge SHALL set occupancy 0, n_valid 0, s_ready 0, and all result outputs and flags 0; rst takes priority over enable, accept and pop.
REQ-030 s_ready SHALL rise on the first edge after rst deasserts when enable = 1; reset during a stall SHALL discard both entries.

Verification (EXP_W=5, MAN_W=10)
REQ-031 Input 0x3C00, n_ready=1 -> next cycle: n_valid=1, sign 0, exp_out 0, mant_out 0x400, is_num=1, is_zero=0.
REQ-032 Input 0x0001 -> exp_out -24 (7'h68), mant_out 0x400; input 0x0200 -> exp_out -15, mant_out 0x400.
REQ-033 Input 0x8000 -> sign 1, exp_out -15, mant_out 0, is_zero=1, is_num=1; input 0x7E00 -> is_nan=1, is_num=0, exp_out 31, mant_out 0x200; input 0xFC00 -> is_ninf=1.
REQ-034 n_ready=0, three back-to-back operands A, B, C -> A and B accepted, s_ready=0 and C held; n_ready=1 -> A, B, C delivered in order, one per cycle, with no loss.
REQ-035 Two entries buffered, then rst=1 for one cycle -> n_valid=0 and outputs zero next cycle; s_ready=1 one cycle after rst deasserts.
REQ-036 One entry buffered, then enable=0 with s_valid=1 -> buffer empty next cycle, operand not accepted, s_ready=0 until one cycle after enable returns high.

Source files
------------

// File: rtl/normalize_param_if.sv
// Operand/result handshake bundle for normalize_param: upstream operand channel
// (s_*) and downstream normalized result channel (n_*) with class flags.
interface normalize_param_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  localparam int XW = EXP_W + 2;

  logic                    s_valid;
  logic                    s_ready;
  logic                    sign_in;
  logic [EXP_W-1:0]        exp_in;
  logic [MAN_W-1:0]        mant_in;

  logic                    n_valid;
  logic                    n_ready;
  logic                    sign_out;
  logic signed [XW-1:0]    exp_out;
  logic [MAN_W:0]          mant_out;
  logic                    is_num;
  logic                    is_zero;
  logic                    is_nan;
  logic                    is_pinf;
  logic                    is_ninf;

  modport master (
    output s_valid, sign_in, exp_in, mant_in, n_ready,
    input  s_ready, n_valid, sign_out, exp_out, mant_out,
           is_num, is_zero, is_nan, is_pinf, is_ninf
  );

  modport slave (
    input  s_valid, sign_in, exp_in, mant_in, n_ready,
    output s_ready, n_valid, sign_out, exp_out, mant_out,
           is_num, is_zero, is_nan, is_pinf, is_ninf
  );
endinterface

// File: rtl/normalize_param.sv
// Classifies IEEE-style operands, normalizes subnormals to a leading-one mantissa
// with an unbiased signed exponent, and queues results in a 2-entry in-order skid buffer.
module normalize_param #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  normalize_param_if.slave bus
);
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int XW   = EXP_W + 2;
  localparam int CW   = $clog2(MAN_W);

  if (EXP_W < 3 || EXP_W > 11 || MAN_W < 2 || MAN_W > 52 ||
      MAN_W >= 3 * 2**(EXP_W-1)) begin : g_bad_params
    $error("normalize_param: EXP_W/MAN_W outside supported range");
  end

  typedef struct packed {
    logic                 sign;
    logic signed [XW-1:0] exp;
    logic [MAN_W:0]       mant;
    logic                 zero;
    logic                 nan;
    logic                 pinf;
    logic                 ninf;
  } ent_t;

  function automatic logic [CW-1:0] f_clz(input logic [MAN_W-1:0] m);
    logic [CW-1:0] c;
    c = '0;
    // Scanning upward lets the highest set bit write last.
    for (int i = 0; i < MAN_W; i++) begin
      if (m[i]) c = CW'(MAN_W - 1 - i);
    end
    return c;
  endfunction

  function automatic ent_t f_normalize(input logic             s,
                                       input logic [EXP_W-1:0] e,
                                       input logic [MAN_W-1:0] m);
    ent_t          r;
    logic [CW-1:0] c;
    r      = '0;
    r.sign = s;
    c      = f_clz(m);
    if (e == '1) begin
      r.exp  = XW'(e);
      r.mant = {1'b0, m};
      if (m != '0)  r.nan  = 1'b1;
      else if (s)   r.ninf = 1'b1;
      else          r.pinf = 1'b1;
    end else if (e == '0) begin
      if (m == '0) begin
        r.exp  = XW'(0) - XW'(BIAS);
        r.zero = 1'b1;
      end else begin
        // Shift past the leading one so the MSB of the result is the hidden bit.
        r.exp  = XW'(0) - XW'(BIAS) - XW'(c);
        r.mant = {1'b0, m} << (32'(c) + 32'd1);
      end
    end else begin
      r.exp  = XW'(e) - XW'(BIAS);
      r.mant = {1'b1, m};
    end
    return r;
  endfunction

  ent_t       w_new_p0;
  logic       w_push_p0;
  logic       w_pop_p0;
  logic       w_wr_hi_p0;
  logic [1:0] w_cnt_nxt_p0;

  logic [1:0] r_cnt_p1;
  logic       r_s_ready_p1;
  ent_t       r_ent0_p1;
  ent_t       r_ent1_p1;
  logic       w_vld_p1;

  always_comb begin
    w_new_p0     = f_normalize(bus.sign_in, bus.exp_in, bus.mant_in);
    w_push_p0    = bus.s_valid && r_s_ready_p1 && enable;
    w_pop_p0     = (r_cnt_p1 != 2'd0) && bus.n_ready;
    w_wr_hi_p0   = (r_cnt_p1 == 2'd1) && !w_pop_p0;
    w_cnt_nxt_p0 = r_cnt_p1 + 2'(w_push_p0) - 2'(w_pop_p0);
  end

  // ---- p0 -> p1: occupancy and registered ready ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_p1     <= 2'd0;
      r_s_ready_p1 <= 1'b0;
    end else if (!enable) begin
      r_cnt_p1     <= 2'd0;
      r_s_ready_p1 <= 1'b0;
    end else begin
      r_cnt_p1     <= w_cnt_nxt_p0;
      r_s_ready_p1 <= (w_cnt_nxt_p0 != 2'd2);
    end
  end

  // Entry storage is never reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (enable) begin
      if (w_pop_p0) r_ent0_p1 <= r_ent1_p1;
      if (w_push_p0) begin
        if (w_wr_hi_p0) r_ent1_p1 <= w_new_p0;
        else            r_ent0_p1 <= w_new_p0;
      end
    end
  end

  // ---- p1: head of buffer drives the result channel ----
  always_comb begin
    w_vld_p1     = (r_cnt_p1 != 2'd0);
    bus.s_ready  = r_s_ready_p1;
    bus.n_valid  = w_vld_p1;
    bus.sign_out = 1'b0;
    bus.exp_out  = '0;
    bus.mant_out = '0;
    bus.is_num   = 1'b0;
    bus.is_zero  = 1'b0;
    bus.is_nan   = 1'b0;
    bus.is_pinf  = 1'b0;
    bus.is_ninf  = 1'b0;
    if (w_vld_p1) begin
      bus.sign_out = r_ent0_p1.sign;
      bus.exp_out  = r_ent0_p1.exp;
      bus.mant_out = r_ent0_p1.mant;
      bus.is_zero  = r_ent0_p1.zero;
      bus.is_nan   = r_ent0_p1.nan;
      bus.is_pinf  = r_ent0_p1.pinf;
      bus.is_ninf  = r_ent0_p1.ninf;
      bus.is_num   = !(r_ent0_p1.nan || r_ent0_p1.pinf || r_ent0_p1.ninf);
    end
  end
endmodule
